// File: rtl/mac_driver.sv
// mac_driver: initiator side of a mac val/rdy link. Buffers one dot-product job,
// streams its {a,b} operand pairs as mac requests and returns the mac response.
module mac_driver #(
  parameter int p_width  = 16,
  parameter int p_nterms = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          job_val,
  output logic                          job_rdy,
  input  logic [2*p_width*p_nterms-1:0] job_msg,
  output logic                          mac_req_val,
  input  logic                          mac_req_rdy,
  output logic [2*p_width-1:0]          mac_req_msg,
  input  logic                          mac_resp_val,
  output logic                          mac_resp_rdy,
  input  logic [p_width-1:0]            mac_resp_msg,
  output logic                          res_val,
  input  logic                          res_rdy,
  output logic [p_width-1:0]            res_msg,
  output logic                          busy
);

  localparam int TermW = 2 * p_width;
  localparam int IdxW  = (p_nterms > 1) ? $clog2(p_nterms) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(p_nterms - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_e;

  state_e                     state_q;
  logic [IdxW-1:0]            idx_q;
  logic [TermW*p_nterms-1:0]  buf_q;
  logic [p_width-1:0]         result_q;
  logic                       job_rdy_q;
  logic                       req_val_q;
  logic                       resp_rdy_q;
  logic                       res_val_q;
  logic                       busy_q;

  // Term 0 sits in the MSBs of the job word; slice the buffer into an indexable array.
  logic [TermW-1:0] req_terms [p_nterms];
  for (genvar gi = 0; gi < p_nterms; gi++) begin : g_terms
    assign req_terms[gi] = buf_q[TermW*(p_nterms-gi)-1 -: TermW];
  end

  assign mac_req_msg  = req_terms[idx_q];
  assign job_rdy      = job_rdy_q;
  assign mac_req_val  = req_val_q;
  assign mac_resp_rdy = resp_rdy_q;
  assign res_val      = res_val_q;
  assign res_msg      = result_q;
  assign busy         = busy_q;

  // Handshake outputs are registered alongside the state so they never depend
  // combinationally on any incoming val or rdy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      buf_q      <= '0;
      result_q   <= '0;
      job_rdy_q  <= 1'b1;
      req_val_q  <= 1'b0;
      resp_rdy_q <= 1'b0;
      res_val_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (job_val && job_rdy_q) begin
            buf_q     <= job_msg;
            idx_q     <= '0;
            state_q   <= S_SEND;
            job_rdy_q <= 1'b0;
            req_val_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_SEND: begin
          if (req_val_q && mac_req_rdy) begin
            if (idx_q == LastIdx) begin
              idx_q      <= '0;
              state_q    <= S_WAIT;
              req_val_q  <= 1'b0;
              resp_rdy_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (mac_resp_val && resp_rdy_q) begin
            result_q   <= mac_resp_msg;
            state_q    <= S_DONE;
            resp_rdy_q <= 1'b0;
            res_val_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (res_val_q && res_rdy) begin
            state_q   <= S_IDLE;
            res_val_q <= 1'b0;
            job_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          job_rdy_q  <= 1'b1;
          req_val_q  <= 1'b0;
          resp_rdy_q <= 1'b0;
          res_val_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_driver.sv
// Bench for mac_driver: a behavioural mac plus a scoreboard of expected request
// terms and job results, driven from a vector table and a few hand sequences.
module tb_mac_driver;
  localparam int W  = 16;
  localparam int NT = 4;
  localparam int JW = 2 * W * NT;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          job_val = 1'b0;
  logic          job_rdy;
  logic [JW-1:0] job_msg = '0;
  logic          mac_req_val;
  logic          mac_req_rdy = 1'b1;
  logic [2*W-1:0] mac_req_msg;
  logic          mac_resp_val = 1'b0;
  logic          mac_resp_rdy;
  logic [W-1:0]  mac_resp_msg = '0;
  logic          res_val;
  logic          res_rdy = 1'b1;
  logic [W-1:0]  res_msg;
  logic          busy;

  always #5 clk = ~clk;

  mac_driver #(.p_width(W), .p_nterms(NT)) dut (
    .clk(clk), .reset(reset),
    .job_val(job_val), .job_rdy(job_rdy), .job_msg(job_msg),
    .mac_req_val(mac_req_val), .mac_req_rdy(mac_req_rdy), .mac_req_msg(mac_req_msg),
    .mac_resp_val(mac_resp_val), .mac_resp_rdy(mac_resp_rdy), .mac_resp_msg(mac_resp_msg),
    .res_val(res_val), .res_rdy(res_rdy), .res_msg(res_msg),
    .busy(busy)
  );

  typedef struct {
    logic [JW-1:0] msg;
    logic [W-1:0]  exp;
  } job_t;

  typedef struct {
    logic [JW-1:0] msg;
    logic [W-1:0]  exp;
    int            req_mode;  // 0 always ready, 1 toggle 1-0-1-0, 2 random
    int            res_mode;  // 0 always ready, 1 hold off 5 cycles, 2 random
    bit            spurious;
    bit            lat;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_done = 0;

  job_t          job_q[$];
  logic [2*W-1:0] term_q[$];
  logic [W-1:0]  res_q[$];

  logic [W-1:0]  acc = '0;
  int            nacc = 0;
  bit            pend = 0;
  logic [W-1:0]  resp_data = '0;
  int            req_mode = 0, res_mode = 0;
  bit            spurious = 0;
  int            send_cnt = 0, hold_cnt = 0;
  bit            prev_stall = 0, prev_res_fire = 0;
  logic [2*W-1:0] prev_msg = '0;
  int            job_fire_cyc = 0, first_req_cyc = 0, last_req_cyc = 0, res_fire_cyc = 0;
  int            nreq = 0;

  vec_t vecs[5];

  function automatic logic [JW-1:0] mk(input logic [W-1:0] a0, b0, a1, b1, a2, b2, a3, b3);
    return {a0, b0, a1, b1, a2, b2, a3, b3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic model_clear();
    job_q.delete();
    term_q.delete();
    res_q.delete();
    acc = '0; nacc = 0; pend = 0;
    prev_stall = 0; prev_res_fire = 0;
    send_cnt = 0; hold_cnt = 0;
    job_val = 1'b0; mac_resp_val = 1'b0;
  endtask

  // One clock: check the current cycle, update the scoreboard on fires,
  // advance past the edge, then drive the next cycle's inputs.
  task automatic tick();
    bit jf, rqf, rsf, rf;
    jf  = job_val && job_rdy;
    rqf = mac_req_val && mac_req_rdy;
    rsf = mac_resp_val && mac_resp_rdy;
    rf  = res_val && res_rdy;

    chk("state_onehot", 64'($countones({job_rdy, mac_req_val, mac_resp_rdy, res_val})), 64'd1);
    chk("busy_vs_idle", 64'(busy), 64'(!job_rdy));
    if (prev_stall) begin
      chk("req_hold_val", 64'(mac_req_val), 64'd1);
      chk("req_hold_msg", 64'(mac_req_msg), 64'(prev_msg));
    end
    if (prev_res_fire) chk("idle_after_res", 64'(job_rdy), 64'd1);
    if (mac_resp_val && !pend) chk("spurious_resp_rdy", 64'(mac_resp_rdy), 64'd0);
    if (res_val && !res_rdy && res_q.size() > 0) begin
      chk("res_held_msg", 64'(res_msg), 64'(res_q[0]));
      chk("res_held_job_rdy", 64'(job_rdy), 64'd0);
      chk("res_held_busy", 64'(busy), 64'd1);
    end

    if (jf) begin
      job_t j;
      j = job_q.pop_front();
      for (int i = 0; i < NT; i++) term_q.push_back(j.msg[2*W*(NT-i)-1 -: 2*W]);
      res_q.push_back(j.exp);
      job_fire_cyc = cyc;
      nreq = 0;
    end
    if (rsf) pend = 0;
    if (rqf) begin
      if (term_q.size() == 0) fail_now("req_unexpected");
      else chk("req_msg", 64'(mac_req_msg), 64'(term_q.pop_front()));
      acc = acc + mac_req_msg[2*W-1:W] * mac_req_msg[W-1:0];
      nacc++;
      nreq++;
      if (nreq == 1) first_req_cyc = cyc;
      last_req_cyc = cyc;
      if (nacc == NT) begin
        pend = 1; resp_data = acc; acc = '0; nacc = 0;
      end
    end
    if (rf) begin
      if (res_q.size() == 0) fail_now("res_unexpected");
      else begin
        logic [W-1:0] e;
        e = res_q.pop_front();
        chk("res_msg", 64'(res_msg), 64'(e));
        $display("job %0d result=0x%04h expected=0x%04h cycle=%0d", n_done, res_msg, e, cyc);
      end
      res_fire_cyc = cyc;
      n_done++;
    end
    prev_stall    = mac_req_val && !mac_req_rdy;
    prev_msg      = mac_req_msg;
    prev_res_fire = rf;

    @(posedge clk);
    #1;
    cyc++;

    job_val = (job_q.size() > 0);
    job_msg = job_val ? job_q[0].msg : '0;

    if (!mac_req_val) begin
      send_cnt = 0;
      mac_req_rdy = (req_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    end else begin
      case (req_mode)
        1:       mac_req_rdy = (send_cnt % 2 == 0);
        2:       mac_req_rdy = 1'($urandom_range(0, 1));
        default: mac_req_rdy = 1'b1;
      endcase
      send_cnt++;
    end

    if (req_mode == 2) mac_resp_val = pend && (mac_resp_val || ($urandom_range(0, 2) == 0));
    else               mac_resp_val = pend;
    mac_resp_msg = resp_data;
    if (spurious && mac_req_val) begin
      mac_resp_val = 1'b1;
      mac_resp_msg = 16'hDEAD;
    end

    if (!res_val) begin
      hold_cnt = 0;
      res_rdy = (res_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    end else begin
      case (res_mode)
        1:       res_rdy = (hold_cnt >= 5);
        2:       res_rdy = 1'($urandom_range(0, 1));
        default: res_rdy = 1'b1;
      endcase
      hold_cnt++;
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (n_done < target && n < budget) begin
      tick();
      n++;
    end
    if (n_done < target) begin
      fail_now(name);
      model_clear();
    end
  endtask

  initial begin
    vecs[0] = '{mk(5, 10, 2, 4, 4, 8, 2, 1),    16'd92,  0, 0, 1'b0, 1'b1};
    vecs[1] = '{mk(0, 0, 0, 0, 0, 0, 0, 0),     16'd0,   0, 0, 1'b0, 1'b1};
    vecs[2] = '{mk(10, 10, 8, 8, 0, 0, 0, 91),  16'd164, 1, 0, 1'b0, 1'b0};
    vecs[3] = '{mk(5, 10, 1, 1, 1, 1, 0, 0),    16'd52,  0, 1, 1'b0, 1'b0};
    vecs[4] = '{mk(3, 3, 3, 3, 3, 3, 3, 3),     16'd36,  0, 0, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_job_rdy", 64'(job_rdy), 64'd1);
    chk("rst_req_val", 64'(mac_req_val), 64'd0);
    chk("rst_resp_rdy", 64'(mac_resp_rdy), 64'd0);
    chk("rst_res_val", 64'(res_val), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_msg", 64'(res_msg), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      int tgt;
      req_mode = vecs[v].req_mode;
      res_mode = vecs[v].res_mode;
      spurious = vecs[v].spurious;
      job_q.push_back('{vecs[v].msg, vecs[v].exp});
      tgt = n_done + 1;
      wait_done(tgt, 100, "vec_timeout");
      if (vecs[v].lat && n_done == tgt) begin
        chk("lat_first_req", 64'(first_req_cyc - job_fire_cyc), 64'd1);
        chk("lat_last_req", 64'(last_req_cyc - job_fire_cyc), 64'(NT));
        chk("lat_res_fire", 64'(res_fire_cyc - job_fire_cyc), 64'(NT + 2));
      end
      tick();
    end
    spurious = 0;
    req_mode = 0;
    res_mode = 0;

    // Back-to-back: two queued jobs, second must be accepted right after IDLE re-entry.
    job_q.push_back('{mk(1, 2, 3, 4, 5, 6, 7, 8), 16'd100});
    job_q.push_back('{mk(9, 9, 0, 0, 0, 0, 1, 1), 16'd82});
    begin
      int first_res;
      wait_done(n_done + 1, 100, "b2b_timeout1");
      first_res = res_fire_cyc;
      wait_done(n_done + 1, 100, "b2b_timeout2");
      chk("b2b_accept", 64'(job_fire_cyc - first_res), 64'd1);
    end

    // Reset mid-job after the second request fire.
    job_q.push_back('{mk(7, 7, 7, 7, 7, 7, 7, 7), 16'd196});
    begin
      int n;
      n = 0;
      while (!(nreq == 2 && term_q.size() == NT - 2) && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) fail_now("rst_mid_timeout");
    end
    reset = 1'b0;
    #1;
    chk("midrst_req_val", 64'(mac_req_val), 64'd0);
    chk("midrst_job_rdy", 64'(job_rdy), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_res_val", 64'(res_val), 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    job_q.push_back('{mk(5, 10, 1, 1, 1, 1, 2, 0), 16'd52});
    wait_done(n_done + 1, 100, "post_rst_timeout");

    // Random jobs with random stalls on every ready.
    req_mode = 2;
    res_mode = 2;
    for (int k = 0; k < 100; k++) begin
      logic [JW-1:0] m;
      logic [W-1:0]  s;
      m = '0;
      s = '0;
      for (int i = 0; i < NT; i++) begin
        logic [W-1:0] a, b;
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        m[2*W*(NT-i)-1 -: 2*W] = {a, b};
        s = s + a * b;
      end
      job_q.push_back('{m, s});
    end
    wait_done(n_done + 100, 8000, "random_timeout");
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
